// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU datapath definitions used by the sequential multiplier
// Contents: default operand width, multiplier FSM state encoding, ALU result-mux select code.
package cpu_defs;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_DONE   = 2'b10,
      ST_UNUSED = 2'b11
   } mult_state_e;

   // Select code of the ALU result 8:1 mux input that carries product_lo.
   localparam logic [2:0] ALU_SEL_MUL = 3'b101;

endpackage

// File: rtl/alu_mult_seq_if.sv
// rtl/alu_mult_seq_if.sv - request/result bundle between the CPU datapath and the multiplier
// Signals: start/op_a/op_b (request), busy/done (status), product_lo/product_hi (result halves).
// Modports: master = requester side, slave = multiplier side.
interface alu_mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product_lo;
   logic [WIDTH-1:0] product_hi;

   modport master (
      output start, op_a, op_b,
      input  busy, done, product_lo, product_hi
   );

   modport slave (
      input  start, op_a, op_b,
      output busy, done, product_lo, product_hi
   );
endinterface

// File: rtl/alu_add32.sv
// rtl/alu_add32.sv - WIDTH-bit unsigned adder with carry out for the multiply accumulate step
// Ports: a, b (addends), sum (WIDTH-bit result), cout (carry out of the top bit).
module alu_add32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - sequential WIDTHxWIDTH unsigned shift-add multiplier, one multiplier bit per clock
// Ports: clk, rst_n (async active-low), bus (slave side of alu_mult_seq_if: start/op_a/op_b in,
//        busy/done/product_lo/product_hi out, all outputs registered).
module alu_mult_seq
   import cpu_defs::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   alu_mult_seq_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   mult_state_e        state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;

   logic [WIDTH-1:0]   add_b;
   logic [WIDTH-1:0]   add_sum;
   logic               add_cout;

   // Gating the addend (rather than the result) keeps a single adder on the accumulate path.
   assign add_b = mplier_q[0] ? mcand_q : '0;

   alu_add32 #(.WIDTH(WIDTH)) u_add (
      .a    (acc_q[2*WIDTH-1:WIDTH]),
      .b    (add_b),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // The accumulator LSB is shifted out every iteration and never read back.
   logic unused_acc_lsb;
   assign unused_acc_lsb = acc_q[0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      lo_d     = lo_q;
      hi_d     = hi_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               mcand_d  = bus.op_a;
               mplier_d = bus.op_b;
               acc_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            // Carry becomes the new MSB after the right shift, so the WIDTH+1-bit sum is kept.
            acc_d    = {add_cout, add_sum, acc_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               // Product registers load on the way into DONE so they are valid in the done cycle.
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               hi_d    = acc_d[2*WIDTH-1:WIDTH];
               lo_d    = acc_d[WIDTH-1:0];
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.product_lo = lo_q;
   assign bus.product_hi = hi_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb/tb_alu_mult_seq.sv - self-checking bench for alu_mult_seq
module tb_alu_mult_seq;
   import cpu_defs::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_mult_seq_if #(.WIDTH(32)) bus ();

   alu_mult_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = -1;
   logic [31:0] held_lo = '0;
   logic [31:0] held_hi = '0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         done_cnt = done_cnt + 1;
         last_done_cyc = cyc;
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Start a multiply in the next cycle and follow it through its 33-cycle window.
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int repulse);
      int  done_before;
      bit  busy_ok, done_ok, hold_ok;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
      done_before = done_cnt;
      busy_ok = 1'b1;
      done_ok = 1'b1;
      hold_ok = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         if (i <= 32) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.done !== 1'b0) done_ok = 1'b0;
            if (bus.product_lo !== held_lo || bus.product_hi !== held_hi) hold_ok = 1'b0;
         end else begin
            if (bus.busy !== 1'b0) busy_ok = 1'b0;
            if (bus.done !== 1'b1) done_ok = 1'b0;
         end
         if (repulse > 0 && i == repulse) begin
            bus.start = 1'b1;
            bus.op_a  = 32'd2;
            bus.op_b  = 32'd2;
         end
         if (repulse > 0 && i == repulse + 1) bus.start = 1'b0;
      end
      #1;
      chk("busy_window", 64'(busy_ok), 64'd1);
      chk("done_only_cycle33", 64'(done_ok), 64'd1);
      chk("hold_during_run", 64'(hold_ok), 64'd1);
      chk("product_lo", 64'(bus.product_lo), 64'(exp_lo));
      chk("product_hi", 64'(bus.product_hi), 64'(exp_hi));
      chk("done_count", 64'(done_cnt - done_before), 64'd1);
      held_lo = exp_lo;
      held_hi = exp_hi;
   endtask

   initial begin
      int prev_done;
      int base_cnt;
      bit quiet_ok;

      vecs[0] = '{32'd3,         32'd5,         32'h0000000F, 32'h00000000};
      vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{32'h12345678,  32'h00000000,  32'h00000000, 32'h00000000};
      vecs[3] = '{32'h00000000,  32'hDEADBEEF,  32'h00000000, 32'h00000000};
      vecs[4] = '{32'h00010000,  32'h00010000,  32'h00000000, 32'h00000001};
      vecs[5] = '{32'h80000000,  32'h00000003,  32'h80000000, 32'h00000001};
      vecs[6] = '{32'hDEADBEEF,  32'h00000001,  32'hDEADBEEF, 32'h00000000};
      vecs[7] = '{32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFE, 32'h00000001};
      vecs[8] = '{32'h12345678,  32'h00000100,  32'h34567800, 32'h00000012};
      vecs[9] = '{32'h0000FFFF,  32'h0000FFFF,  32'hFFFE0001, 32'h00000000};

      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_done", 64'(bus.done), 64'd0);
      chk("reset_lo", 64'(bus.product_lo), 64'd0);
      chk("reset_hi", 64'(bus.product_hi), 64'd0);
      rst_n = 1'b1;

      // Table runs are issued back to back: each start lands in the first IDLE cycle.
      for (int v = 0; v < 10; v++) begin
         prev_done = last_done_cyc;
         run_mul(vecs[v].a, vecs[v].b, vecs[v].lo, vecs[v].hi, 0);
         if (v > 0) chk("b2b_spacing", 64'(last_done_cyc - prev_done), 64'd34);
      end

      // 7 x 9 with start re-pulsed and operands changed to 2 x 2 in RUN cycle 10.
      run_mul(32'd7, 32'd9, 32'h0000003F, 32'h0, 10);
      base_cnt = done_cnt;
      repeat (40) @(negedge clk);
      chk("no_extra_done", 64'(done_cnt - base_cnt), 64'd0);

      // Reset in cycle 10 of 100 x 200: outputs clear at once, no done.
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.op_a  = 32'd100;
      bus.op_b  = 32'd200;
      @(posedge clk); #1;
      bus.start = 1'b0;
      base_cnt = done_cnt;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", 64'(bus.busy), 64'd0);
      chk("midreset_done", 64'(bus.done), 64'd0);
      chk("midreset_lo", 64'(bus.product_lo), 64'd0);
      chk("midreset_hi", 64'(bus.product_hi), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      quiet_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0) quiet_ok = 1'b0;
      end
      chk("abandoned_idle", 64'(quiet_ok), 64'd1);
      chk("abandoned_no_done", 64'(done_cnt - base_cnt), 64'd0);
      held_lo = '0;
      held_hi = '0;
      run_mul(32'd6, 32'd7, 32'd42, 32'd0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
